cmn_rst_seq: RTL and testbench

CMN_RST_SEQ -- requirements
Module: cmn_rst_seq

---
 rtl/cmn_rst_seq_if.sv | 12 +
 rtl/cmn_rst_seq.sv | 99 +++++++++
 tb/tb_cmn_rst_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cmn_rst_seq_if.sv
// Soft-reset request/status bundle between a reset sequencer and its requester.
interface cmn_rst_seq_if;
    logic       req;
    logic       rst_n;
    logic       busy;
    logic       done;
    logic       ack;
    logic [7:0] rst_count;

    modport master (output req, input rst_n, busy, done, ack, rst_count);
    modport slave  (input req, output rst_n, busy, done, ack, rst_count);
endinterface

// File: rtl/cmn_rst_seq.sv
// Reset sequencer: holds rst_n low ASSERT_CYCLES, then settles SETTLE_CYCLES before done.
// Latency: ack/rst_n respond one clk after req is sampled; all outputs registered.
// Backpressure: none; req always accepted, and a req during a sequence restarts the low pulse.
module cmn_rst_seq #(
    parameter int unsigned ASSERT_CYCLES = 16,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    cmn_rst_seq_if.slave  bus
);
    typedef enum logic [1:0] {ST_ASSERT, ST_SETTLE, ST_IDLE} state_t;

    localparam logic [7:0] ASSERT_LAST = 8'(ASSERT_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
    localparam bit         SKIP_SETTLE = (SETTLE_CYCLES == 0);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rst_count_q;
    logic       rst_n_q, busy_q, done_q, ack_q;
    logic       done_d, ack_d, inc_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        done_d  = 1'b0;
        ack_d   = 1'b0;
        inc_d   = 1'b0;
        case (state_q)
            ST_ASSERT: begin
                // A req here only stretches the pulse; it is not a new reset.
                if (bus.req) begin
                    cnt_d = 8'd0;
                    ack_d = 1'b1;
                end else if (cnt_q == ASSERT_LAST) begin
                    cnt_d = 8'd0;
                    if (SKIP_SETTLE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (bus.req) begin
                    state_d = ST_ASSERT;
                    cnt_d   = 8'd0;
                    ack_d   = 1'b1;
                    inc_d   = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                    done_d  = 1'b1;
                end
            end
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (bus.req) begin
                    state_d = ST_ASSERT;
                    ack_d   = 1'b1;
                    inc_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= 8'd0;
            rst_n_q     <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            rst_count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_n_q <= (state_d != ST_ASSERT);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= done_d;
            ack_q   <= ack_d;
            if (inc_d && (rst_count_q != 8'hFF))
                rst_count_q <= rst_count_q + 8'd1;
        end
    end

    assign bus.rst_n     = rst_n_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ack       = ack_q;
    assign bus.rst_count = rst_count_q;
endmodule

// File: tb/tb_cmn_rst_seq.sv
// Directed bench for cmn_rst_seq: default instance plus an ASSERT_CYCLES=1/SETTLE_CYCLES=0 instance.
module tb_cmn_rst_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmn_rst_seq_if bus_a();
    cmn_rst_seq_if bus_b();

    cmn_rst_seq dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    cmn_rst_seq #(.ASSERT_CYCLES(1), .SETTLE_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int checks = 0;
    int errors = 0;

    int w_low, w_settle, w_done_at, w_ndone, w_nack, w_ack_at, w_both;
    bit w_busy_done;

    // Samples one instance per negedge; index 1 is the first window observed.
    // req is pulsed for one cycle after sampling indices inj_a / inj_b.
    task automatic watch(input bit sel, input int inj_a, input int inj_b, input int budget);
        bit r, b, d, a;
        w_low = 0; w_settle = 0; w_done_at = 0; w_ndone = 0;
        w_nack = 0; w_ack_at = 0; w_both = 0; w_busy_done = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (sel) begin r = bus_b.rst_n; b = bus_b.busy; d = bus_b.done; a = bus_b.ack; end
            else     begin r = bus_a.rst_n; b = bus_a.busy; d = bus_a.done; a = bus_a.ack; end
            if (!r) w_low++;
            if (r && b) w_settle++;
            if (d) begin
                w_ndone++;
                if (w_done_at == 0) begin w_done_at = i; w_busy_done = b; end
            end
            if (a) begin
                w_nack++;
                if (w_ack_at == 0) w_ack_at = i;
            end
            if (a && d) w_both++;
            if (sel) bus_b.req = (i == inj_a) || (i == inj_b);
            else     bus_a.req = (i == inj_a) || (i == inj_b);
            if (w_done_at != 0 && i >= w_done_at + 4) break;
        end
        bus_a.req = 1'b0;
        bus_b.req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus_a.req = 1'b0;
        bus_b.req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_a.rst_n !== 1'b0) begin errors++; $display("FAIL rst_rst_n got %0b exp 0", bus_a.rst_n); end
        checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %0b exp 1", bus_a.busy); end
        checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", bus_a.done); end
        checks++; if (bus_a.rst_count !== 8'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus_a.rst_count); end
        bus_a.req = 1'b1;
        @(negedge clk);
        checks++; if (bus_a.ack !== 1'b0) begin errors++; $display("FAIL rst_req_ignored_ack got %0b exp 0", bus_a.ack); end
        checks++; if (bus_a.rst_count !== 8'd0) begin errors++; $display("FAIL rst_req_ignored_count got %0d exp 0", bus_a.rst_count); end
        bus_a.req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        watch(1'b0, 0, 0, 60);
        checks++; if (w_low !== 16) begin errors++; $display("FAIL por_low got %0d exp 16", w_low); end
        checks++; if (w_settle !== 4) begin errors++; $display("FAIL por_settle got %0d exp 4", w_settle); end
        checks++; if (w_done_at !== 21) begin errors++; $display("FAIL por_done_at got %0d exp 21", w_done_at); end
        checks++; if (w_ndone !== 1) begin errors++; $display("FAIL por_ndone got %0d exp 1", w_ndone); end
        checks++; if (w_busy_done !== 1'b0) begin errors++; $display("FAIL por_busy_idle got %0b exp 0", w_busy_done); end
        checks++; if (w_nack !== 0) begin errors++; $display("FAIL por_ack got %0d exp 0", w_nack); end
        checks++; if (bus_a.rst_count !== 8'd0) begin errors++; $display("FAIL por_count got %0d exp 0", bus_a.rst_count); end
        checks++; if (bus_b.rst_n !== 1'b1 || bus_b.busy !== 1'b0) begin errors++; $display("FAIL por_b_idle got rst_n=%0b busy=%0b exp 1 0", bus_b.rst_n, bus_b.busy); end
    endtask

    task automatic test_soft;
        watch(1'b0, 1, 0, 60);
        checks++; if (w_ack_at !== 2) begin errors++; $display("FAIL soft_ack_at got %0d exp 2", w_ack_at); end
        checks++; if (w_low !== 16) begin errors++; $display("FAIL soft_low got %0d exp 16", w_low); end
        checks++; if (w_settle !== 4) begin errors++; $display("FAIL soft_settle got %0d exp 4", w_settle); end
        checks++; if (w_done_at !== 22) begin errors++; $display("FAIL soft_done_at got %0d exp 22", w_done_at); end
        checks++; if (w_both !== 0) begin errors++; $display("FAIL soft_ack_done got %0d exp 0", w_both); end
        checks++; if (bus_a.rst_count !== 8'd1) begin errors++; $display("FAIL soft_count got %0d exp 1", bus_a.rst_count); end
    endtask

    task automatic test_retrigger;
        watch(1'b0, 1, 12, 80);
        checks++; if (w_low !== 27) begin errors++; $display("FAIL retrig_low got %0d exp 27", w_low); end
        checks++; if (w_nack !== 2) begin errors++; $display("FAIL retrig_nack got %0d exp 2", w_nack); end
        checks++; if (w_done_at !== 33) begin errors++; $display("FAIL retrig_done_at got %0d exp 33", w_done_at); end
        checks++; if (w_ndone !== 1) begin errors++; $display("FAIL retrig_ndone got %0d exp 1", w_ndone); end
        checks++; if (bus_a.rst_count !== 8'd2) begin errors++; $display("FAIL retrig_count got %0d exp 2", bus_a.rst_count); end
    endtask

    task automatic test_abort;
        watch(1'b0, 1, 20, 80);
        checks++; if (w_low !== 32) begin errors++; $display("FAIL abort_low got %0d exp 32", w_low); end
        checks++; if (w_settle !== 7) begin errors++; $display("FAIL abort_settle got %0d exp 7", w_settle); end
        checks++; if (w_done_at !== 41) begin errors++; $display("FAIL abort_done_at got %0d exp 41", w_done_at); end
        checks++; if (w_ndone !== 1) begin errors++; $display("FAIL abort_ndone got %0d exp 1", w_ndone); end
        checks++; if (bus_a.rst_count !== 8'd4) begin errors++; $display("FAIL abort_count got %0d exp 4", bus_a.rst_count); end
    endtask

    task automatic test_req_at_exit;
        watch(1'b0, 1, 21, 80);
        checks++; if (w_low !== 32) begin errors++; $display("FAIL exit_low got %0d exp 32", w_low); end
        checks++; if (w_settle !== 8) begin errors++; $display("FAIL exit_settle got %0d exp 8", w_settle); end
        checks++; if (w_done_at !== 42) begin errors++; $display("FAIL exit_done_at got %0d exp 42", w_done_at); end
        checks++; if (w_both !== 0) begin errors++; $display("FAIL exit_ack_done got %0d exp 0", w_both); end
        checks++; if (bus_a.rst_count !== 8'd6) begin errors++; $display("FAIL exit_count got %0d exp 6", bus_a.rst_count); end
    endtask

    task automatic test_held_req;
        int n_ack = 0;
        int n_low = 0;
        @(negedge clk);
        bus_a.req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_a.ack) n_ack++;
            if (!bus_a.rst_n) n_low++;
        end
        bus_a.req = 1'b0;
        checks++; if (n_ack !== 40) begin errors++; $display("FAIL held_ack got %0d exp 40", n_ack); end
        checks++; if (n_low !== 40) begin errors++; $display("FAIL held_low got %0d exp 40", n_low); end
        checks++; if (bus_a.rst_count !== 8'd7) begin errors++; $display("FAIL held_count got %0d exp 7", bus_a.rst_count); end
        watch(1'b0, 0, 0, 60);
        checks++; if (w_low !== 15) begin errors++; $display("FAIL held_tail_low got %0d exp 15", w_low); end
        checks++; if (w_done_at !== 20) begin errors++; $display("FAIL held_done_at got %0d exp 20", w_done_at); end
    endtask

    task automatic test_mid_rst;
        bus_a.req = 1'b1;
        @(negedge clk);
        bus_a.req = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus_a.rst_count !== 8'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", bus_a.rst_count); end
        checks++; if (bus_a.rst_n !== 1'b0 || bus_a.busy !== 1'b1) begin errors++; $display("FAIL midrst_outs got rst_n=%0b busy=%0b exp 0 1", bus_a.rst_n, bus_a.busy); end
        checks++; if (bus_a.ack !== 1'b0 || bus_a.done !== 1'b0) begin errors++; $display("FAIL midrst_pulses got ack=%0b done=%0b exp 0 0", bus_a.ack, bus_a.done); end
        @(posedge clk);
        #1 rst = 1'b0;
        watch(1'b0, 0, 0, 60);
        checks++; if (w_low !== 16) begin errors++; $display("FAIL midrst_por_low got %0d exp 16", w_low); end
        checks++; if (w_done_at !== 21) begin errors++; $display("FAIL midrst_por_done_at got %0d exp 21", w_done_at); end
        checks++; if (bus_a.rst_count !== 8'd0) begin errors++; $display("FAIL midrst_por_count got %0d exp 0", bus_a.rst_count); end
    endtask

    task automatic test_corner;
        watch(1'b1, 1, 0, 20);
        checks++; if (w_low !== 1) begin errors++; $display("FAIL corner_low got %0d exp 1", w_low); end
        checks++; if (w_settle !== 0) begin errors++; $display("FAIL corner_settle got %0d exp 0", w_settle); end
        checks++; if (w_done_at !== 3) begin errors++; $display("FAIL corner_done_at got %0d exp 3", w_done_at); end
        checks++; if (w_busy_done !== 1'b0) begin errors++; $display("FAIL corner_busy_idle got %0b exp 0", w_busy_done); end
        checks++; if (bus_b.rst_count !== 8'd1) begin errors++; $display("FAIL corner_count got %0d exp 1", bus_b.rst_count); end
        watch(1'b1, 1, 2, 20);
        checks++; if (w_low !== 2) begin errors++; $display("FAIL corner_retrig_low got %0d exp 2", w_low); end
        checks++; if (w_nack !== 2) begin errors++; $display("FAIL corner_retrig_nack got %0d exp 2", w_nack); end
        checks++; if (w_done_at !== 4) begin errors++; $display("FAIL corner_retrig_done_at got %0d exp 4", w_done_at); end
        checks++; if (bus_b.rst_count !== 8'd2) begin errors++; $display("FAIL corner_retrig_count got %0d exp 2", bus_b.rst_count); end
    endtask

    task automatic test_saturation;
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            bus_a.req = 1'b1;
            @(negedge clk);
            bus_a.req = 1'b0;
            repeat (25) @(negedge clk);
            if (k == 254) begin
                checks++; if (bus_a.rst_count !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d exp 254", bus_a.rst_count); end
            end
            if (k == 255) begin
                checks++; if (bus_a.rst_count !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", bus_a.rst_count); end
            end
        end
        checks++; if (bus_a.rst_count !== 8'd255) begin errors++; $display("FAIL sat_260 got %0d exp 255", bus_a.rst_count); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL sat_idle_busy got %0b exp 0", bus_a.busy); end
    endtask

    initial begin
        test_reset();
        test_soft();
        test_retrigger();
        test_abort();
        test_req_at_exit();
        test_held_req();
        test_mid_rst();
        test_corner();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
